// File: rtl/bram_responder.sv
// bram_responder: valid/ready front end for a byte-strobed 32-bit memory port,
// backed by an inferred four-lane block RAM with read-first behaviour.
// Define BRAM_RESPONDER_UNALIGNED_EN to support unaligned, word-crossing
// accesses (second access state ACC_B). Without it every access is aligned.
module bram_responder #(
   parameter int    ADDRESS_BITWIDTH = 16,
   parameter string INIT_FILE        = ""
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_address,
   input  logic [3:0]  req_write_enable,
   input  logic [31:0] req_data_in,
   output logic        resp_valid,
   output logic [31:0] resp_data_out
);

   localparam int WORD_BITS = ADDRESS_BITWIDTH - 2;
   localparam int DEPTH     = 1 << WORD_BITS;
`ifdef BRAM_RESPONDER_UNALIGNED_EN
   localparam int LANES = 8;   // lanes of word A (3:0) and word B (7:4)
`else
   localparam int LANES = 4;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC_A = 2'd1,
`ifdef BRAM_RESPONDER_UNALIGNED_EN
      ACC_B = 2'd2,
`endif
      RESP  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [WORD_BITS-1:0]   word_a_q, word_a_d;
   logic [LANES-1:0]       mask_q, mask_d;
   logic [8*LANES-1:0]     wdata_q, wdata_d;
   logic [31:0]            resp_data_q, resp_data_d;
`ifdef BRAM_RESPONDER_UNALIGNED_EN
   logic [1:0]             offset_q, offset_d;
   logic [31:0]            hold_q, hold_d;
   logic [63:0]            joined;
`endif

   logic [WORD_BITS-1:0]   bram_addr;
   logic [3:0]             bram_we;
   logic [31:0]            bram_wdata;
   logic [31:0]            bram_rdata;
   logic [31:0]            mem [DEPTH];

   // Address bits outside the decoded word range are intentionally ignored.
   logic unused_addr_bits;
`ifdef BRAM_RESPONDER_UNALIGNED_EN
   assign unused_addr_bits = ^req_address[31:ADDRESS_BITWIDTH];
`else
   assign unused_addr_bits = ^{req_address[31:ADDRESS_BITWIDTH], req_address[1:0]};
`endif

   // Next-state, request latching, BRAM port control and response outputs.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d       = state_q;
      word_a_d      = word_a_q;
      mask_d        = mask_q;
      wdata_d       = wdata_q;
      resp_data_d   = resp_data_q;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_data_out = resp_data_q;
      bram_addr     = word_a_q;
      bram_we       = '0;
      bram_wdata    = wdata_q[31:0];
`ifdef BRAM_RESPONDER_UNALIGNED_EN
      offset_d      = offset_q;
      hold_d        = hold_q;
      joined        = {bram_rdata, hold_q} >> {offset_q, 3'b000};
`endif
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               word_a_d = req_address[ADDRESS_BITWIDTH-1:2];
`ifdef BRAM_RESPONDER_UNALIGNED_EN
               offset_d = req_address[1:0];
               mask_d   = {4'b0000, req_write_enable} << req_address[1:0];
               wdata_d  = {32'h0, req_data_in} << {req_address[1:0], 3'b000};
`else
               mask_d   = req_write_enable;
               wdata_d  = req_data_in;
`endif
               state_d  = ACC_A;
            end
         end
         ACC_A: begin
            bram_we = mask_q[3:0];
`ifdef BRAM_RESPONDER_UNALIGNED_EN
            state_d = (offset_q != 2'd0) ? ACC_B : RESP;
`else
            state_d = RESP;
`endif
         end
`ifdef BRAM_RESPONDER_UNALIGNED_EN
         ACC_B: begin
            hold_d     = bram_rdata;              // word A, read before its write
            bram_addr  = word_a_q + WORD_BITS'(1); // wraps from depth-1 to 0
            bram_we    = mask_q[7:4];
            bram_wdata = wdata_q[63:32];
            state_d    = RESP;
         end
`endif
         RESP: begin
            resp_valid = 1'b1;
`ifdef BRAM_RESPONDER_UNALIGNED_EN
            resp_data_d = (offset_q == 2'd0) ? bram_rdata : joined[31:0];
`else
            resp_data_d = bram_rdata;
`endif
            resp_data_out = resp_data_d;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A reset cycle aborts the in-flight access: no write, no response.
      if (sys_rst) begin
         req_ready     = 1'b0;
         resp_valid    = 1'b0;
         resp_data_out = resp_data_q;
         bram_we       = '0;
      end
   end

   // Control state and the held response word, cleared by reset.
   always_ff @(posedge sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (sys_rst) begin
         state_q     <= IDLE;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         resp_data_q <= resp_data_d;
      end
   end

   // Request datapath registers; only meaningful after an accept, so no reset.
   always_ff @(posedge sys_clk) begin
      word_a_q <= word_a_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
`ifdef BRAM_RESPONDER_UNALIGNED_EN
      offset_q <= offset_d;
      hold_q   <= hold_d;
`endif
   end

   // Power-up image of the RAM: all bytes zero.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   // Read-first byte-write block RAM.
   always_ff @(posedge sys_clk) begin
      // NOTE: the memory array has no reset so it maps onto block RAM; reset leaves contents intact.
      bram_rdata <= mem[bram_addr];
      for (int l = 0; l < 4; l++) begin
         if (bram_we[l]) mem[bram_addr][8*l +: 8] <= bram_wdata[8*l +: 8];
      end
   end

endmodule

// File: tb/tb_bram_responder.sv
// tb_bram_responder: table-driven requests with a response scoreboard, plus
// hand-written sequences for reset, mid-operation reset and throughput.
module tb_bram_responder;

   logic        sys_clk;
   logic        sys_rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_address;
   logic [3:0]  req_write_enable;
   logic [31:0] req_data_in;
   logic        resp_valid;
   logic [31:0] resp_data_out;

   bram_responder #(.ADDRESS_BITWIDTH(16)) dut (
      .sys_clk          (sys_clk),
      .sys_rst          (sys_rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_address      (req_address),
      .req_write_enable (req_write_enable),
      .req_data_in      (req_data_in),
      .resp_valid       (resp_valid),
      .resp_data_out    (resp_data_out)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] data;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      int          lat;
      int          acc;
      int          tag;
   } sb_t;

   vec_t vecs [$];
   sb_t  sb   [$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   always @(posedge sys_clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Response monitor: every pulse must match the oldest outstanding request.
   always @(negedge sys_clk) begin
      if (resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check($sformatf("req%0d_data", e.tag), resp_data_out, e.exp);
            check($sformatf("req%0d_latency", e.tag), cyc - e.acc, e.lat);
         end
      end
   end

   // Entered at a negedge; leaves at the negedge after the accept.
   task automatic issue(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                        input logic [31:0] exp, input int lat, input int tag);
      int waited = 0;
      while (req_ready !== 1'b1 && waited < 20) begin
         @(negedge sys_clk);
         waited++;
      end
      check($sformatf("req%0d_ready", tag), {31'b0, req_ready}, 32'd1);
      if (req_ready !== 1'b1) return;
      req_valid        = 1'b1;
      req_address      = a;
      req_write_enable = we;
      req_data_in      = d;
      sb.push_back('{exp, lat, cyc, tag});
      @(negedge sys_clk);
      req_valid        = 1'b0;
      req_address      = $urandom;
      req_write_enable = 4'($urandom);
      req_data_in      = $urandom;
   endtask

   task automatic drain(input string name);
      int waited = 0;
      while (sb.size() != 0 && waited < 20) begin
         @(negedge sys_clk);
         waited++;
      end
      check(name, sb.size(), 32'd0);
   endtask

   initial begin
      int n_acc;
      int last_acc;
`ifdef BRAM_RESPONDER_UNALIGNED_EN
      vecs.push_back('{32'h0000_0004, 4'b0001, 32'habcd_ef12, 32'h0000_0000, 2});
      vecs.push_back('{32'h0000_0004, 4'b0000, 32'h0000_0000, 32'h0000_0012, 2});
      vecs.push_back('{32'h0000_0008, 4'b1111, 32'h1122_3344, 32'h0000_0000, 2});
      vecs.push_back('{32'h0000_0009, 4'b0000, 32'h0000_0000, 32'h0011_2233, 3});
      vecs.push_back('{32'h0000_000e, 4'b1111, 32'haabb_ccdd, 32'h0000_0000, 3});
      vecs.push_back('{32'h0000_000c, 4'b0000, 32'h0000_0000, 32'hccdd_0000, 2});
      vecs.push_back('{32'h0000_0010, 4'b0000, 32'h0000_0000, 32'h0000_aabb, 2});
      vecs.push_back('{32'h0000_fffc, 4'b1111, 32'h4433_2211, 32'h0000_0000, 2});
      vecs.push_back('{32'h0000_0000, 4'b0001, 32'h0000_0055, 32'h0000_0000, 2});
      vecs.push_back('{32'h0000_fffd, 4'b0000, 32'h0000_0000, 32'h5544_3322, 3});
      vecs.push_back('{32'h0000_ffff, 4'b0011, 32'h0000_9988, 32'h0000_5544, 3});
      vecs.push_back('{32'h0000_fffc, 4'b0000, 32'h0000_0000, 32'h8833_2211, 2});
      vecs.push_back('{32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0099, 2});
      vecs.push_back('{32'h0000_000d, 4'b0001, 32'h0000_005a, 32'hbbcc_dd00, 3});
      vecs.push_back('{32'h0000_000d, 4'b0000, 32'h0000_0000, 32'hbbcc_dd5a, 3});
      vecs.push_back('{32'h0000_000f, 4'b0000, 32'hffff_ffff, 32'h00aa_bbcc, 3});
      vecs.push_back('{32'h0000_000c, 4'b0000, 32'h0000_0000, 32'hccdd_5a00, 2});
`else
      vecs.push_back('{32'h0000_0004, 4'b0001, 32'habcd_ef12, 32'h0000_0000, 2});
      vecs.push_back('{32'h0000_0004, 4'b0000, 32'h0000_0000, 32'h0000_0012, 2});
      vecs.push_back('{32'h0000_0005, 4'b0000, 32'h0000_0000, 32'h0000_0012, 2});
      vecs.push_back('{32'h0000_0007, 4'b0000, 32'h0000_0000, 32'h0000_0012, 2});
      vecs.push_back('{32'h0000_0008, 4'b1111, 32'h1122_3344, 32'h0000_0000, 2});
      vecs.push_back('{32'h0000_0009, 4'b0110, 32'haaaa_bbbb, 32'h1122_3344, 2});
      vecs.push_back('{32'h0000_0008, 4'b0000, 32'h0000_0000, 32'h11aa_bb44, 2});
      vecs.push_back('{32'h0000_fffc, 4'b1000, 32'hdead_beef, 32'h0000_0000, 2});
      vecs.push_back('{32'h0001_fffc, 4'b0000, 32'h0000_0000, 32'hde00_0000, 2});
      vecs.push_back('{32'h0001_0008, 4'b0001, 32'h0000_0000, 32'h11aa_bb44, 2});
      vecs.push_back('{32'habcd_000a, 4'b0000, 32'h0000_0000, 32'h11aa_bb00, 2});
      vecs.push_back('{32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 2});
      vecs.push_back('{32'h0000_0008, 4'b0000, 32'hffff_ffff, 32'h11aa_bb00, 2});
      vecs.push_back('{32'h0000_000b, 4'b0000, 32'h0000_0000, 32'h11aa_bb00, 2});
`endif

      sys_rst          = 1'b1;
      req_valid        = 1'b0;
      req_address      = '0;
      req_write_enable = '0;
      req_data_in      = '0;

      // Reset state.
      repeat (3) @(negedge sys_clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_data", resp_data_out, 32'd0);
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      @(negedge sys_clk);
      check("post_rst_ready", {31'b0, req_ready}, 32'd1);
      check("post_rst_resp_data", resp_data_out, 32'd0);

      // Table of single requests.
      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i].addr, vecs[i].we, vecs[i].data, vecs[i].exp, vecs[i].lat, i);
      end
      drain("table_drain");

      // Response data holds between pulses.
      repeat (3) @(negedge sys_clk);
      check("resp_hold", resp_data_out, vecs[vecs.size()-1].exp);

      // Reset during an in-flight write: no response, ready low then high.
      req_valid        = 1'b1;
`ifdef BRAM_RESPONDER_UNALIGNED_EN
      req_address      = 32'h0000_0021;
`else
      req_address      = 32'h0000_0040;
`endif
      req_write_enable = 4'b1111;
      req_data_in      = 32'h1234_5678;
      @(posedge sys_clk);
      #1 req_valid = 1'b0;
`ifdef BRAM_RESPONDER_UNALIGNED_EN
      @(posedge sys_clk);   // reset lands in ACC_B
`endif
      #1 sys_rst = 1'b1;
      @(negedge sys_clk);
      check("midrst_ready_low", {31'b0, req_ready}, 32'd0);
      check("midrst_no_resp", {31'b0, resp_valid}, 32'd0);
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      @(negedge sys_clk);
      check("midrst_ready_after", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("midrst_quiet%0d", i), {31'b0, resp_valid}, 32'd0);
         @(negedge sys_clk);
      end
`ifdef BRAM_RESPONDER_UNALIGNED_EN
      issue(32'h0000_0020, 4'b0000, 32'h0, 32'h3456_7800, 2, 50);
      issue(32'h0000_0024, 4'b0000, 32'h0, 32'h0000_0000, 2, 51);
`else
      issue(32'h0000_0004, 4'b0000, 32'h0, 32'h0000_0012, 2, 50);
`endif
      drain("midrst_drain");

      // Throughput: valid held high, aligned reads accepted every 3rd cycle.
      n_acc            = 0;
      last_acc         = 0;
      req_valid        = 1'b1;
      req_address      = 32'h0000_0004;
      req_write_enable = 4'b0000;
      req_data_in      = 32'h0;
      for (int i = 0; i < 12; i++) begin
         if (req_ready === 1'b1) begin
            sb.push_back('{32'h0000_0012, 2, cyc, 100 + n_acc});
            if (n_acc > 0) check($sformatf("thru_gap%0d", n_acc), cyc - last_acc, 32'd3);
            last_acc = cyc;
            n_acc++;
         end
         @(negedge sys_clk);
      end
      req_valid = 1'b0;
      check("thru_accepts", n_acc, 32'd4);
      drain("thru_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
